// File: rtl/spislaveio.sv
// ---------------------------------------------------------------------------
// spislaveio -- CPU-bus SPI target (mode 0, MSB first).
//
// The responder end of an SPI link. An external SPI host exchanges bytes with
// the CPU through a one-byte RX holding register and a one-byte TX buffer.
// A level interrupt is raised on RX-full and/or TX-empty when enabled.
// The SPI pins are asynchronous and are oversampled in the clk domain.
//
// Register map (AD):
//   0 DATA    rd: RX byte (clears RXF)   wr: TX buffer (clears TXE)
//   1 STATUS  ro: {IRQ, 3'b0, SEL, OVR, TXE, RXF}
//   2 CTRL    {5'b0, OVRCLR (write-only, self-clearing), TXIE, RXIE}
//   others    read 8'hFF, writes ignored
//
// Ports:
//   clk      in   system clock, single domain
//   rst      in   synchronous active-high reset
//   irq      out  level interrupt, (RXIE & RXF) | (TXIE & TXE), registered
//   AD       in   register select
//   DI       in   CPU write data
//   DO       out  CPU read data, combinational from AD
//   rw       in   1 = read, 0 = write
//   cs       in   chip select (decode && vma)
//   ssel_n   in   SPI target select, active low, asynchronous
//   sclk     in   SPI clock, idle low, asynchronous
//   mosi     in   SPI data in, asynchronous
//   miso     out  SPI data out (MSB of the TX shifter while selected)
//   miso_oe  out  high while selected
//
// CPU handshake: a write lands on the clk edge where cs && !rw; a DATA read
// side effect applies on every edge where cs && rw && AD == 0, so stretched
// read cycles are harmless.
// ---------------------------------------------------------------------------
module spislaveio #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic       ssel_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection. These flops are deliberately
    // not reset: they keep tracking the pins through rst, so a host that
    // holds ssel_n low across reset does not produce a false select edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ssel_prev_q;
    logic                   sclk_prev_q;
    logic                   ssel_s, sclk_s, mosi_s;
    logic                   ssel_fall, ssel_rise, sclk_rise, sclk_fall;

    always_ff @(posedge clk) begin
        ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel_n};
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ssel_prev_q <= ssel_s;
        sclk_prev_q <= sclk_s;
    end

    assign ssel_s    = ssel_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ssel_fall =  ssel_prev_q & ~ssel_s;
    assign ssel_rise = ~ssel_prev_q &  ssel_s;
    assign sclk_rise = ~sclk_prev_q &  sclk_s;
    assign sclk_fall =  sclk_prev_q & ~sclk_s;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       rxf_q, rxf_d;
    logic       txe_q, txe_d;
    logic       ovr_q, ovr_d;
    logic       rxie_q, rxie_d;
    logic       txie_q, txie_d;
    logic       irq_q, irq_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic [7:0] txbuf_q, txbuf_d;
    logic [6:0] rxshift_q, rxshift_d;  // 7 bits: the 8th arrives with the wrap
    logic [7:0] txshift_q, txshift_d;
    logic [2:0] bitcnt_q, bitcnt_d;

    logic       wr_data, rd_data, wr_ctrl;
    logic       byte_done;
    logic [7:0] tx_load;

    assign wr_data = cs & ~rw & (AD == 3'd0);
    assign rd_data = cs &  rw & (AD == 3'd0);
    assign wr_ctrl = cs & ~rw & (AD == 3'd2);

    // Byte handed to the shifter on select or on the byte boundary; an empty
    // buffer underruns to the fill byte. Always uses pre-write buffer state.
    assign tx_load = txe_q ? FILL_BYTE : txbuf_q;

    always_comb begin
        state_d   = state_q;
        rxf_d     = rxf_q;
        txe_d     = txe_q;
        ovr_d     = ovr_q;
        rxie_d    = rxie_q;
        txie_d    = txie_q;
        rxdata_d  = rxdata_q;
        txbuf_d   = txbuf_q;
        rxshift_d = rxshift_q;
        txshift_d = txshift_q;
        bitcnt_d  = bitcnt_q;
        byte_done = 1'b0;

        // SPI side. In IDLE any sclk edge is ignored, including one that
        // lands in the same synced cycle as the select.
        case (state_q)
            ST_IDLE: begin
                if (ssel_fall) begin
                    state_d   = ST_SEL;
                    txshift_d = tx_load;
                    txe_d     = 1'b1;
                    bitcnt_d  = 3'd0;
                end
            end
            ST_SEL: begin
                if (ssel_rise) begin
                    // Partial RX and unsent TX bits are simply dropped.
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                end else if (sclk_rise) begin
                    rxshift_d = {rxshift_q[5:0], mosi_s};
                    bitcnt_d  = bitcnt_q + 3'd1;
                    byte_done = (bitcnt_q == 3'd7);
                end else if (sclk_fall) begin
                    if (bitcnt_q == 3'd0) begin
                        txshift_d = tx_load;
                        txe_d     = 1'b1;
                    end else begin
                        txshift_d = {txshift_q[6:0], 1'b1};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU side. A DATA write after a same-cycle reload still lands and
        // leaves TXE clear.
        if (rd_data) begin
            rxf_d = 1'b0;
        end
        if (wr_data) begin
            txbuf_d = DI;
            txe_d   = 1'b0;
        end
        if (wr_ctrl) begin
            rxie_d = DI[0];
            txie_d = DI[1];
            if (DI[2]) begin
                ovr_d = 1'b0;
            end
        end

        // Byte completion beats a concurrent DATA read: RXF stays set and the
        // byte being read out is not counted as overrun.
        if (byte_done) begin
            rxdata_d = {rxshift_q, mosi_s};
            ovr_d    = ovr_d | (rxf_q & ~rd_data);
            rxf_d    = 1'b1;
        end

        irq_d = (rxie_d & rxf_d) | (txie_d & txe_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rxf_q     <= 1'b0;
            txe_q     <= 1'b1;
            ovr_q     <= 1'b0;
            rxie_q    <= 1'b0;
            txie_q    <= 1'b0;
            irq_q     <= 1'b0;
            rxdata_q  <= 8'h00;
            txbuf_q   <= FILL_BYTE;
            rxshift_q <= 7'h00;
            txshift_q <= 8'h00;
            bitcnt_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            rxf_q     <= rxf_d;
            txe_q     <= txe_d;
            ovr_q     <= ovr_d;
            rxie_q    <= rxie_d;
            txie_q    <= txie_d;
            irq_q     <= irq_d;
            rxdata_q  <= rxdata_d;
            txbuf_q   <= txbuf_d;
            rxshift_q <= rxshift_d;
            txshift_q <= txshift_d;
            bitcnt_q  <= bitcnt_d;
        end
    end

    assign irq     = irq_q;
    assign miso    = txshift_q[7] & (state_q == ST_SEL);
    assign miso_oe = (state_q == ST_SEL);

    always_comb begin
        DO = 8'hFF;
        case (AD)
            3'd0:    DO = rxdata_q;
            3'd1:    DO = {irq_q, 3'b000, (state_q == ST_SEL), ovr_q, txe_q, rxf_q};
            3'd2:    DO = {5'b00000, 1'b0, txie_q, rxie_q};
            default: DO = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_spislaveio.sv
// ---------------------------------------------------------------------------
// Bench for spislaveio: register-access vector table, directed SPI sequences
// for the multi-cycle corner cases, and randomized whole-transfer sessions
// checked against a transaction-level model of the register flags.
// ---------------------------------------------------------------------------
module tb_spislaveio;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int NV          = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       ssel_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_ad;
        logic [7:0] wr_dat;
        logic [2:0] rd_ad;
        logic [7:0] exp_do;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [NV];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    spislaveio #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .AD     (AD),
        .DI     (DI),
        .DO     (DO),
        .rw     (rw),
        .cs     (cs),
        .ssel_n (ssel_n),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .miso_oe(miso_oe)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: run still active at %0t, limit 900000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        ssel_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // ---------------- CPU bus drivers ----------------
    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b1; AD = a;
        @(negedge clk);
        d = DO;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        cpu_read(a, d);
        check(name, d, exp);
    endtask

    // ---------------- SPI host drivers ----------------
    // Pins change 2 ns after a clk edge, i.e. asynchronously to the sampler.
    task automatic spi_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Mode 0: host drives mosi while sclk is low, samples miso on the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            spi_wait(half);
            sclk = 1'b1;
            rx   = {rx[6:0], miso};
            spi_wait(half);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_deselect();
        ssel_n = 1'b1;
        spi_wait(LAT + 2);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] rx, d, w, mo, exp_b, exp_st;
    logic [2:0] c;
    logic       got;
    int         half, nb;
    logic       m_rxf, m_txe, m_ovr, m_rxie, m_txie;
    logic [7:0] m_txbuf, m_rxdata;

    initial begin
        vecs[0] = '{1'b0, 3'd0, 8'h00, 3'd1, 8'h02, 1'b0};  // STATUS after reset
        vecs[1] = '{1'b0, 3'd0, 8'h00, 3'd2, 8'h00, 1'b0};  // CTRL after reset
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 8'hFF, 1'b0};  // unmapped
        vecs[3] = '{1'b0, 3'd0, 8'h00, 3'd7, 8'hFF, 1'b0};  // unmapped
        vecs[4] = '{1'b1, 3'd2, 8'h03, 3'd2, 8'h03, 1'b1};  // TXIE with TXE -> irq
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd1, 8'h82, 1'b1};  // STATUS shows IRQ
        vecs[6] = '{1'b1, 3'd0, 8'h5E, 3'd1, 8'h00, 1'b0};  // TX write clears TXE
        vecs[7] = '{1'b1, 3'd5, 8'hAA, 3'd2, 8'h03, 1'b0};  // unmapped write ignored
        vecs[8] = '{1'b1, 3'd2, 8'h07, 3'd2, 8'h03, 1'b0};  // OVRCLR self-clears
        vecs[9] = '{1'b1, 3'd2, 8'h00, 3'd0, 8'h00, 1'b0};  // rxdata reset value

        // Reset state and register table
        do_reset();
        @(negedge clk);
        check_bit("reset irq", irq, 1'b0);
        check_bit("reset miso", miso, 1'b0);
        check_bit("reset miso_oe", miso_oe, 1'b0);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr_en) cpu_write(vecs[i].wr_ad, vecs[i].wr_dat);
            cpu_read(vecs[i].rd_ad, d);
            check($sformatf("vec%0d DO", i), d, vecs[i].exp_do);
            check_bit($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
        end

        // 1: basic full-duplex byte
        do_reset();
        cpu_write(3'd0, 8'hA5);
        ssel_n = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        check_bit("t1 miso_oe selected", miso_oe, 1'b1);
        check_bit("t1 first miso bit", miso, 1'b1);
        spi_bits(8'h3C, 8, 4, rx);
        check("t1 host rx", rx, 8'hA5);
        spi_wait(4);
        spi_deselect();
        check_bit("t1 miso_oe released", miso_oe, 1'b0);
        rd_check(3'd1, 8'h03, "t1 status");
        rd_check(3'd0, 8'h3C, "t1 data");
        rd_check(3'd1, 8'h02, "t1 status after read");

        // 2: underrun and overrun, then OVRCLR
        do_reset();
        ssel_n = 1'b0;
        spi_bits(8'h11, 8, 4, rx);
        check("t2 host rx 1", rx, 8'hFF);
        spi_bits(8'h22, 8, 4, rx);
        check("t2 host rx 2", rx, 8'hFF);
        spi_wait(4);
        spi_deselect();
        rd_check(3'd1, 8'h07, "t2 status overrun");
        rd_check(3'd0, 8'h22, "t2 data");
        cpu_write(3'd2, 8'h04);
        rd_check(3'd1, 8'h02, "t2 status after ovrclr");
        rd_check(3'd2, 8'h00, "t2 ctrl readback");

        // 3: RX interrupt latency and clear on DATA read
        do_reset();
        cpu_write(3'd2, 8'h01);
        ssel_n = 1'b0;
        spi_bits(8'h5A, 7, 4, rx);
        mosi = 1'b0;
        spi_wait(4);
        check_bit("t3 irq before 8th bit", irq, 1'b0);
        sclk = 1'b1;
        got = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            if (irq) begin
                got = 1'b1;
                break;
            end
        end
        check_bit("t3 irq within latency bound", got, 1'b1);
        spi_wait(4);
        sclk = 1'b0;
        spi_wait(4);
        spi_deselect();
        rd_check(3'd1, 8'h83, "t3 status");
        cpu_read(3'd0, d);
        check("t3 data", d, 8'h5A);
        @(negedge clk);
        check_bit("t3 irq cleared by read", irq, 1'b0);

        // 4: deselect mid-byte, then a clean byte
        do_reset();
        ssel_n = 1'b0;
        spi_bits(8'hFF, 5, 4, rx);
        spi_wait(4);
        spi_deselect();
        rd_check(3'd1, 8'h02, "t4 status after abort");
        ssel_n = 1'b0;
        spi_bits(8'hC3, 8, 4, rx);
        check("t4 host rx", rx, 8'hFF);
        spi_wait(4);
        spi_deselect();
        rd_check(3'd0, 8'hC3, "t4 data aligned");

        // 5: byte completion in the same clk as a DATA read, with RXF set
        do_reset();
        ssel_n = 1'b0;
        spi_bits(8'h96, 8, 4, rx);
        spi_wait(4);
        spi_deselect();
        ssel_n = 1'b0;
        spi_bits(8'h4B, 7, 4, rx);
        mosi = 1'b1;
        spi_wait(4);
        sclk = 1'b1;            // completion lands LAT edges later
        @(posedge clk);
        cpu_read(3'd0, d);      // read edge is the completion edge
        check("t5 read returns previous byte", d, 8'h96);
        rd_check(3'd1, 8'h0B, "t5 status selected");
        spi_wait(4);
        sclk = 1'b0;
        spi_wait(4);
        spi_deselect();
        rd_check(3'd1, 8'h03, "t5 status");
        rd_check(3'd0, 8'h4B, "t5 data");

        // 6: reset mid-transfer, ssel_n held low through it
        do_reset();
        cpu_write(3'd2, 8'h03);
        ssel_n = 1'b0;
        spi_bits(8'hF0, 4, 4, rx);
        cpu_write(3'd0, 8'h77);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("t6 miso_oe after rst", miso_oe, 1'b0);
        check_bit("t6 irq after rst", irq, 1'b0);
        rd_check(3'd1, 8'h02, "t6 status after rst");
        rd_check(3'd2, 8'h00, "t6 ctrl after rst");
        rd_check(3'd0, 8'h00, "t6 data after rst");
        spi_deselect();
        ssel_n = 1'b0;
        spi_bits(8'h81, 8, 4, rx);
        check("t6 host rx", rx, 8'hFF);
        spi_wait(4);
        spi_deselect();
        rd_check(3'd0, 8'h81, "t6 data");

        // Randomized sessions against a transaction-level flag model
        do_reset();
        m_rxf = 1'b0; m_txe = 1'b1; m_ovr = 1'b0; m_rxie = 1'b0; m_txie = 1'b0;
        m_txbuf = 8'hFF; m_rxdata = 8'h00;
        for (int it = 0; it < 40; it++) begin
            c = 3'($urandom_range(0, 7));
            cpu_write(3'd2, {5'b00000, c});
            m_rxie = c[0];
            m_txie = c[1];
            if (c[2]) m_ovr = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                cpu_write(3'd0, w);
                m_txbuf = w;
                m_txe   = 1'b0;
            end
            half = $urandom_range(3, 6);
            nb   = $urandom_range(1, 2);
            ssel_n = 1'b0;
            for (int b = 0; b < nb; b++) begin
                // each byte boundary pulls the buffer (or the fill byte)
                exp_q.push_back(m_txe ? 8'hFF : m_txbuf);
                m_txe = 1'b1;
                mo = 8'($urandom);
                spi_bits(mo, 8, half, rx);
                exp_b = exp_q.pop_front();
                check($sformatf("rand%0d miso byte%0d", it, b), rx, exp_b);
                m_ovr    = m_ovr | m_rxf;
                m_rxf    = 1'b1;
                m_rxdata = mo;
            end
            spi_wait(half);
            spi_deselect();
            exp_st = {((m_rxie & m_rxf) | (m_txie & m_txe)), 3'b000, 1'b0, m_ovr, m_txe, m_rxf};
            rd_check(3'd1, exp_st, $sformatf("rand%0d status", it));
            check_bit($sformatf("rand%0d irq", it), irq, exp_st[7]);
            if ($urandom_range(0, 1) == 1) begin
                rd_check(3'd0, m_rxdata, $sformatf("rand%0d data", it));
                m_rxf = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
